// File: rtl/sync_down_counter_pkg.sv
// Shared constants and helpers for the cascadable down counter.
// Digit width is fixed; total width scales with the digit count.
package sync_down_counter_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_ONES = 4'hF;

  function automatic int width_of(input int digits);
    return DIGIT_W * digits;
  endfunction

endpackage

// File: rtl/sync_down_counter_digit.sv
// One 4-bit down-counting cell: load or wrap from D, otherwise decrement on EN_IN.
// One cycle from any sampled control to Q; ZERO is combinational from Q.
module down_digit
  import sync_down_counter_pkg::*;
(
  input  logic               CLK,
  input  logic               MR,
  input  logic               LOAD,
  input  logic               EN_IN,
  input  logic               WRAP,
  input  logic [DIGIT_W-1:0] D,
  output logic [DIGIT_W-1:0] Q,
  output logic               ZERO
);

  // WRAP only fires on an enabled terminal count, so it shares the load path.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      Q <= '0;
    end else if (!LOAD || WRAP) begin
      Q <= D;
    end else if (EN_IN) begin
      Q <= Q - 4'd1;
    end
  end

  assign ZERO = (Q == '0);

endmodule

// File: rtl/sync_down_counter.sv
// Cascadable W-bit down counter with parallel load, auto-reload and borrow/underflow flags.
// Q updates one cycle after a sampled load/count; BO is combinational, UF is registered.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter  int DIGITS = 2,
  localparam int W      = width_of(DIGITS)
) (
  input  logic         CLK,
  input  logic         MR,
  input  logic         LOAD,
  input  logic         EN,
  input  logic         ARL,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         BO,
  output logic         UF
);

  logic [DIGITS-1:0] zero;
  logic [DIGITS-1:0] en_chain;
  logic              tc;
  logic [W-1:0]      reload_dat;

  assign BO = &zero;
  assign tc = EN & BO;

  // Load always takes D; a terminal-count wrap takes D only when auto-reloading.
  assign reload_dat = (!LOAD || ARL) ? D : {DIGITS{DIGIT_ONES}};

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_first
      assign en_chain[k] = EN;
    end else begin : g_next
      assign en_chain[k] = en_chain[k-1] & zero[k-1];
    end

    down_digit u_digit (
      .CLK   (CLK),
      .MR    (MR),
      .LOAD  (LOAD),
      .EN_IN (en_chain[k]),
      .WRAP  (tc),
      .D     (reload_dat[k*DIGIT_W +: DIGIT_W]),
      .Q     (Q[k*DIGIT_W +: DIGIT_W]),
      .ZERO  (zero[k])
    );
  end

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      UF <= 1'b0;
    end else if (!LOAD) begin
      UF <= 1'b0;
    end else begin
      UF <= tc;
    end
  end

endmodule
